// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the two-core coherence bus controller.
package coherence_bus_ctrl_pkg;

  localparam int unsigned CPUS   = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;

  // Core index; the controller is written for exactly two cores.
  typedef logic core_idx_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SNOOP      = 3'd1,
    SNOOP_RESP = 3'd2,
    PEER_WB    = 3'd3,
    DSERV      = 3'd4,
    ISERV      = 3'd5
  } bus_state_t;

  function automatic core_idx_t peer_of(core_idx_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and RAM-side signals of the coherence bus controller.
interface coherence_bus_ctrl_if;
  import coherence_bus_ctrl_pkg::*;

  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0][WORD_W-1:0] iload;

  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][ADDR_W-1:0] daddr;
  logic [CPUS-1:0][WORD_W-1:0] dstore;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0][WORD_W-1:0] dload;

  logic [CPUS-1:0]             cctrans;
  logic [CPUS-1:0]             ccwrite;
  logic [CPUS-1:0]             ccwait;
  logic [CPUS-1:0]             ccinv;
  logic [CPUS-1:0][ADDR_W-1:0] ccsnoopaddr;

  logic                        ramREN;
  logic                        ramWEN;
  logic [ADDR_W-1:0]           ramaddr;
  logic [WORD_W-1:0]           ramstore;
  logic [WORD_W-1:0]           ramload;
  logic                        ram_ready;

  // Caches and RAM side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

  // Controller side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ram_ready,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: dcache class beats icache class, ties go to
// the core that did not win last.
module rr_arbiter2
  import coherence_bus_ctrl_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      grant_en_i,
  input  logic [1:0] dreq_i,
  input  logic [1:0] ireq_i,
  output core_idx_t winner_o,
  output logic      valid_o,
  output logic      dclass_o
);

  core_idx_t  rr_last_q;
  logic [1:0] cand;

  // Pick the request class, then the winner within it.
  always_comb begin
    dclass_o = |dreq_i;
    cand     = dclass_o ? dreq_i : ireq_i;
    valid_o  = |cand;
    case (cand)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~rr_last_q;
      default: winner_o = 1'b0;
    endcase
  end

  // Remember the last granted core; reset makes core 0 win the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_last_q <= 1'b1;
    end else if (grant_en_i && valid_o) begin
      rr_last_q <= winner_o;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI coherence bus controller: arbitrates the single-ported RAM,
// snoops the peer dcache on miss fills and forces peer writebacks first.
module coherence_bus_ctrl #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) (
  input logic                 CLK,
  input logic                 nRST,
  coherence_bus_ctrl_if.slave bus
);
  import coherence_bus_ctrl_pkg::*;

  bus_state_t        state_q;
  core_idx_t         owner_q;
  core_idx_t         peer;
  logic [ADDR_W-1:0] snoop_addr_q;
  logic              snoop_inv_q;

  core_idx_t         winner;
  logic              win_valid;
  logic              win_dclass;
  logic [CPUS-1:0]   dreq;

  assign dreq = bus.dREN | bus.dWEN;
  assign peer = peer_of(owner_q);

  rr_arbiter2 u_arb (
    .CLK        (CLK),
    .nRST       (nRST),
    .grant_en_i (state_q == IDLE),
    .dreq_i     (dreq),
    .ireq_i     (bus.iREN),
    .winner_o   (winner),
    .valid_o    (win_valid),
    .dclass_o   (win_dclass)
  );

  // Bus FSM; snoop address/invalidate are captured at grant and held until DSERV.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      snoop_addr_q <= '0;
      snoop_inv_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            owner_q <= winner;
            if (!win_dclass) begin
              state_q <= ISERV;
            end else if (bus.cctrans[winner]) begin
              state_q      <= SNOOP;
              snoop_addr_q <= bus.daddr[winner];
              snoop_inv_q  <= bus.ccwrite[winner];
            end else begin
              state_q <= DSERV;
            end
          end
        end
        SNOOP:      state_q <= SNOOP_RESP;
        SNOOP_RESP: state_q <= bus.dWEN[peer] ? PEER_WB : DSERV;
        PEER_WB: begin
          if (!bus.dWEN[peer]) state_q <= DSERV;
        end
        DSERV: begin
          if (!(bus.cctrans[owner_q] || bus.dREN[owner_q] || bus.dWEN[owner_q])) begin
            state_q <= IDLE;
          end
        end
        ISERV: begin
          if (bus.ram_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output muxing; wait deasserts combinationally with ram_ready for zero added latency.
  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    case (state_q)
      SNOOP, SNOOP_RESP: begin
        bus.ccwait[peer]      = 1'b1;
        bus.ccinv[peer]       = snoop_inv_q;
        bus.ccsnoopaddr[peer] = snoop_addr_q;
      end
      PEER_WB: begin
        bus.ccwait[peer]      = 1'b1;
        bus.ccinv[peer]       = snoop_inv_q;
        bus.ccsnoopaddr[peer] = snoop_addr_q;
        // Gated so the cycle after the peer drops dWEN writes nothing stale.
        bus.ramWEN            = bus.dWEN[peer];
        bus.ramaddr           = bus.daddr[peer];
        bus.ramstore          = bus.dstore[peer];
        bus.dwait[peer]       = ~bus.ram_ready;
      end
      DSERV: begin
        bus.ramWEN         = bus.dWEN[owner_q];
        bus.ramREN         = bus.dREN[owner_q] & ~bus.dWEN[owner_q];
        bus.ramaddr        = bus.daddr[owner_q];
        bus.ramstore       = bus.dstore[owner_q];
        bus.dload[owner_q] = bus.ramload;
        bus.dwait[owner_q] = ~bus.ram_ready;
      end
      ISERV: begin
        bus.ramREN         = 1'b1;
        bus.ramaddr        = bus.iaddr[owner_q];
        bus.iload[owner_q] = bus.ramload;
        bus.iwait[owner_q] = ~bus.ram_ready;
      end
      default: ;
    endcase
  end

  // Simultaneous read and write from the owner dcache is illegal stimulus.
  dserv_rw_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
    (state_q == DSERV) |-> !(bus.dREN[owner_q] && bus.dWEN[owner_q]));

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed self-checking bench for coherence_bus_ctrl.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if bus ();

  coherence_bus_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic clear_inputs();
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.ramload = '0; bus.ram_ready = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
      $display("FAIL rst_state: got %0d want %0d", dut.state_q, IDLE); end
    n_checks++; if ({bus.iwait, bus.dwait} !== 4'b1111) begin n_fail++;
      $display("FAIL rst_waits: got %b want 1111", {bus.iwait, bus.dwait}); end
    n_checks++; if ({bus.ccwait, bus.ccinv, bus.ramREN, bus.ramWEN} !== 6'b0) begin n_fail++;
      $display("FAIL rst_ctl: got %b want 000000",
               {bus.ccwait, bus.ccinv, bus.ramREN, bus.ramWEN}); end
    n_checks++; if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload, bus.ccsnoopaddr} !== '0)
    begin n_fail++; $display("FAIL rst_data: nonzero data outputs, ramaddr %h", bus.ramaddr); end
    nRST = 1'b1;
    // Reset asserted in the middle of a DSERV access.
    @(negedge CLK); bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h10;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== DSERV || bus.ramREN !== 1'b1) begin n_fail++;
      $display("FAIL rst_pre_dserv: got state %0d ramREN %b want %0d 1",
               dut.state_q, bus.ramREN, DSERV); end
    nRST = 1'b0; #1;
    n_checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin n_fail++;
      $display("FAIL rst_mid_ram: got %b want 00", {bus.ramREN, bus.ramWEN}); end
    n_checks++; if ({bus.iwait, bus.dwait} !== 4'b1111) begin n_fail++;
      $display("FAIL rst_mid_waits: got %b want 1111", {bus.iwait, bus.dwait}); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
      $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, IDLE); end
    clear_inputs();
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_iread();
    @(negedge CLK); bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40;
    @(negedge CLK);
    n_checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 2'b11)
    begin n_fail++; $display("FAIL iread_req: got ren %b addr %h iwait %b want 1 40 11",
                             bus.ramREN, bus.ramaddr, bus.iwait); end
    @(negedge CLK); bus.ram_ready = 1'b1; bus.ramload = 32'hDEADBEEF; #1;
    n_checks++; if (bus.iwait !== 2'b10) begin n_fail++;
      $display("FAIL iread_wait: got %b want 10", bus.iwait); end
    n_checks++; if (bus.iload[0] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL iread_data: got %h want deadbeef", bus.iload[0]); end
    @(negedge CLK); bus.ram_ready = 1'b0; bus.iREN[0] = 1'b0; #1;
    n_checks++; if (dut.state_q !== IDLE || bus.iwait !== 2'b11 || bus.ramREN !== 1'b0)
    begin n_fail++; $display("FAIL iread_done: got state %0d iwait %b ren %b want %0d 11 0",
                             dut.state_q, bus.iwait, bus.ramREN, IDLE); end
  endtask

  task automatic test_coherent_read();
    @(negedge CLK);
    bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b0; bus.daddr[0] = 32'h100;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== SNOOP || bus.ccwait !== 2'b10 || bus.ccinv !== 2'b00)
    begin n_fail++; $display("FAIL cr_snoop: got state %0d ccwait %b ccinv %b want %0d 10 00",
                             dut.state_q, bus.ccwait, bus.ccinv, SNOOP); end
    n_checks++; if (bus.ccsnoopaddr[1] !== 32'h100 || bus.ramREN !== 1'b0) begin n_fail++;
      $display("FAIL cr_snoopaddr: got %h ren %b want 100 0", bus.ccsnoopaddr[1], bus.ramREN); end
    @(negedge CLK);
    n_checks++; if (dut.state_q !== SNOOP_RESP || bus.ccwait !== 2'b10) begin n_fail++;
      $display("FAIL cr_resp: got state %0d ccwait %b want %0d 10",
               dut.state_q, bus.ccwait, SNOOP_RESP); end
    @(negedge CLK); bus.ram_ready = 1'b1; bus.ramload = 32'h11111111; #1;
    n_checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.ccwait !== 2'b00)
    begin n_fail++; $display("FAIL cr_word0_req: got ren %b addr %h ccwait %b want 1 100 00",
                             bus.ramREN, bus.ramaddr, bus.ccwait); end
    n_checks++; if (bus.dwait !== 2'b10 || bus.dload[0] !== 32'h11111111) begin n_fail++;
      $display("FAIL cr_word0: got dwait %b data %h want 10 11111111", bus.dwait, bus.dload[0]); end
    @(negedge CLK); bus.ram_ready = 1'b0; bus.daddr[0] = 32'h104; #1;
    n_checks++; if (dut.state_q !== DSERV || bus.dwait !== 2'b11 || bus.ramaddr !== 32'h104)
    begin n_fail++; $display("FAIL cr_word1_req: got state %0d dwait %b addr %h want %0d 11 104",
                             dut.state_q, bus.dwait, bus.ramaddr, DSERV); end
    @(negedge CLK); bus.ram_ready = 1'b1; bus.ramload = 32'h22222222; #1;
    n_checks++; if (bus.dwait !== 2'b10 || bus.dload[0] !== 32'h22222222) begin n_fail++;
      $display("FAIL cr_word1: got dwait %b data %h want 10 22222222", bus.dwait, bus.dload[0]); end
    @(negedge CLK); bus.ram_ready = 1'b0; bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
      $display("FAIL cr_idle: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_peer_wb();
    @(negedge CLK);
    bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h200;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== SNOOP || bus.ccwait !== 2'b01 || bus.ccinv !== 2'b01 ||
                    bus.ccsnoopaddr[0] !== 32'h200) begin n_fail++;
      $display("FAIL pw_snoop: got state %0d ccwait %b ccinv %b addr %h want %0d 01 01 200",
               dut.state_q, bus.ccwait, bus.ccinv, bus.ccsnoopaddr[0], SNOOP); end
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'hAAAA0000;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== SNOOP_RESP || bus.dwait[1] !== 1'b1) begin n_fail++;
      $display("FAIL pw_resp: got state %0d dwait1 %b want %0d 1",
               dut.state_q, bus.dwait[1], SNOOP_RESP); end
    @(negedge CLK);
    n_checks++; if (dut.state_q !== PEER_WB || bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0)
    begin n_fail++; $display("FAIL pw_state: got state %0d wen %b ren %b want %0d 1 0",
                             dut.state_q, bus.ramWEN, bus.ramREN, PEER_WB); end
    n_checks++; if (bus.ramaddr !== 32'h200 || bus.ramstore !== 32'hAAAA0000 ||
                    bus.ccinv[0] !== 1'b1 || bus.dwait !== 2'b11) begin n_fail++;
      $display("FAIL pw_bus: got addr %h store %h inv %b dwait %b want 200 aaaa0000 1 11",
               bus.ramaddr, bus.ramstore, bus.ccinv[0], bus.dwait); end
    bus.ram_ready = 1'b1; #1;
    n_checks++; if (bus.dwait !== 2'b10) begin n_fail++;
      $display("FAIL pw_peer_done: got dwait %b want 10", bus.dwait); end
    @(negedge CLK); bus.ram_ready = 1'b0; bus.dWEN[0] = 1'b0; #1;
    n_checks++; if (dut.state_q !== PEER_WB || bus.dwait[1] !== 1'b1) begin n_fail++;
      $display("FAIL pw_hold: got state %0d dwait1 %b want %0d 1",
               dut.state_q, bus.dwait[1], PEER_WB); end
    @(negedge CLK);
    n_checks++; if (dut.state_q !== DSERV || bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 ||
                    bus.ramaddr !== 32'h200 || bus.ccwait !== 2'b00) begin n_fail++;
      $display("FAIL pw_fill_req: got state %0d ren %b wen %b addr %h ccwait %b",
               dut.state_q, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ccwait); end
    bus.ram_ready = 1'b1; bus.ramload = 32'hAAAA0000; #1;
    n_checks++; if (bus.dwait !== 2'b01 || bus.dload[1] !== 32'hAAAA0000) begin n_fail++;
      $display("FAIL pw_fill: got dwait %b data %h want 01 aaaa0000", bus.dwait, bus.dload[1]); end
    @(negedge CLK);
    bus.ram_ready = 1'b0; bus.dREN[1] = 1'b0; bus.cctrans[1] = 1'b0; bus.ccwrite[1] = 1'b0;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
      $display("FAIL pw_idle: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_d_over_i();
    @(negedge CLK);
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h80; bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h300;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== DSERV || bus.ramaddr !== 32'h300 || bus.iwait !== 2'b11)
    begin n_fail++; $display("FAIL doi_dfirst: got state %0d addr %h iwait %b want %0d 300 11",
                             dut.state_q, bus.ramaddr, bus.iwait, DSERV); end
    bus.ram_ready = 1'b1; bus.ramload = 32'h33333333; #1;
    n_checks++; if (bus.dwait !== 2'b01 || bus.dload[1] !== 32'h33333333) begin n_fail++;
      $display("FAIL doi_ddata: got dwait %b data %h want 01 33333333", bus.dwait, bus.dload[1]); end
    @(negedge CLK); bus.dREN[1] = 1'b0; bus.ram_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
      $display("FAIL doi_idle: got %0d want %0d", dut.state_q, IDLE); end
    @(negedge CLK);
    n_checks++; if (dut.state_q !== ISERV || bus.ramaddr !== 32'h80) begin n_fail++;
      $display("FAIL doi_isecond: got state %0d addr %h want %0d 80",
               dut.state_q, bus.ramaddr, ISERV); end
    bus.ram_ready = 1'b1; bus.ramload = 32'h44444444; #1;
    n_checks++; if (bus.iwait !== 2'b10 || bus.iload[0] !== 32'h44444444) begin n_fail++;
      $display("FAIL doi_idata: got iwait %b data %h want 10 44444444", bus.iwait, bus.iload[0]); end
    @(negedge CLK); bus.iREN[0] = 1'b0; bus.ram_ready = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_w;
    logic [31:0] exp_a;
    // Fresh reset so core 0 wins the first tie.
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    bus.daddr[0] = 32'h400; bus.daddr[1] = 32'h500; bus.iaddr[0] = 32'h600; bus.iaddr[1] = 32'h700;
    bus.dREN = 2'b11; bus.iREN = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_w = 2'b11; exp_w[k % 2] = 1'b0;
      exp_a = (k % 2 == 1) ? 32'h500 : 32'h400;
      @(negedge CLK); bus.ram_ready = 1'b1; bus.ramload = 32'h1000 + k; #1;
      n_checks++; if (dut.state_q !== DSERV || bus.ramaddr !== exp_a || bus.dwait !== exp_w)
      begin n_fail++; $display("FAIL b2b_grant%0d: got state %0d addr %h dwait %b want %0d %h %b",
                               k, dut.state_q, bus.ramaddr, bus.dwait, DSERV, exp_a, exp_w); end
      @(negedge CLK); bus.dREN[k % 2] = 1'b0; bus.ram_ready = 1'b0;
      @(negedge CLK);
      n_checks++; if (dut.state_q !== IDLE) begin n_fail++;
        $display("FAIL b2b_idle%0d: got %0d want %0d", k, dut.state_q, IDLE); end
      if (k < 3) bus.dREN[k % 2] = 1'b1;
      else bus.dREN = 2'b00;
    end
    for (int j = 0; j < 2; j++) begin
      exp_w = 2'b11; exp_w[j] = 1'b0;
      exp_a = (j == 1) ? 32'h700 : 32'h600;
      @(negedge CLK); bus.ram_ready = 1'b1; bus.ramload = 32'h5000 + j; #1;
      n_checks++; if (dut.state_q !== ISERV || bus.ramaddr !== exp_a || bus.iwait !== exp_w)
      begin n_fail++; $display("FAIL b2b_ifetch%0d: got state %0d addr %h iwait %b want %0d %h %b",
                               j, dut.state_q, bus.ramaddr, bus.iwait, ISERV, exp_a, exp_w); end
      @(negedge CLK); bus.iREN[j] = 1'b0; bus.ram_ready = 1'b0;
    end
    @(negedge CLK);
    n_checks++; if (dut.state_q !== IDLE || {bus.ramREN, bus.ramWEN} !== 2'b00) begin n_fail++;
      $display("FAIL b2b_end: got state %0d ram %b want %0d 00",
               dut.state_q, {bus.ramREN, bus.ramWEN}, IDLE); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_iread();
    test_coherent_read();
    test_peer_wb();
    test_d_over_i();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Shared memory/coherence controller for a 2-core system; sits between both cores' icache/dcache ports and the single-ported RAM.
- Arbitrates RAM among the requesters.
- Sequences snoop/invalidate transactions to the peer dcache, and forces a peer dirty writeback before serving the requester, so the caches stay MSI-coherent.

Parameters:
- CPUS, 2, number of cores; logic below is written for 2, other values unsupported.
- ADDR_W, 32, byte address width.
- WORD_W, 32, data word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  icache read request, per core.
- iaddr  in  CPUS x ADDR_W  icache address.
- iwait  out  CPUS  icache stall; low for exactly the cycle iload is valid.
- iload  out  CPUS x WORD_W  instruction data.
- dREN  in  CPUS  dcache read.
- dWEN  in  CPUS  dcache write.
- daddr  in  CPUS x ADDR_W  dcache address.
- dstore  in  CPUS x WORD_W  dcache write data.
- dwait  out  CPUS  dcache stall; low for the cycle the access completes.
- dload  out  CPUS x WORD_W  dcache read data.
- cctrans  in  CPUS  coherent transaction (miss fill) in progress.
- ccwrite  in  CPUS  fill is write-intent (invalidate peers).
- ccwait  out  CPUS  snoop in progress; target cache must service the snoop.
- ccinv  out  CPUS  invalidate the snooped block.
- ccsnoopaddr  out  CPUS x ADDR_W  address being snooped.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ram_ready  in  1  RAM completes the current access this cycle.

Behaviour:
- Reset values:
  - state IDLE; owner 0; rr_last 1 (core 0 wins the first tie).
  - iwait, dwait all 1; ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN all 0.
  - ramaddr, ramstore, iload, dload all 0.
- Reset mid-transaction aborts it with no RAM side effects beyond the current cycle.
- Arbitration, evaluated in IDLE only:
  - dcache requests (dREN|dWEN) beat icache requests (iREN).
  - Between cores at the same class, round-robin: the core not equal to rr_last wins.
  - Grant is registered: 1 cycle from IDLE to the serving state.
  - rr_last is updated at grant.
- States:
  - IDLE: no RAM access.
    - dcache winner with cctrans=1 -> SNOOP.
    - dcache winner with cctrans=0 (writeback or halt flush) -> DSERV.
    - icache winner only -> ISERV.
  - SNOOP: 1 cycle.
    - ccwait[peer]=1; ccsnoopaddr[peer]=daddr[owner]; ccinv[peer]=ccwrite[owner]. Same values held through SNOOP_RESP and PEER_WB.
    - -> SNOOP_RESP.
  - SNOOP_RESP: 1 cycle sample of the peer.
    - Peer dWEN=1 (dirty hit, peer writing back) -> PEER_WB.
    - Otherwise -> DSERV.
  - PEER_WB: RAM driven from the peer's daddr/dstore with ramWEN=1.
    - dwait[peer]=~ram_ready.
    - After each ram_ready, if peer dWEN is still 1, stay; when the peer drops dWEN -> DSERV.
  - DSERV: RAM driven from the owner's dREN/dWEN/daddr/dstore.
    - dload[owner]=ramload; dwait[owner]=~ram_ready.
    - Held across multi-word block fills: stay while the owner's cctrans=1 or it asserts dREN/dWEN.
    - Owner drops all three -> IDLE.
  - ISERV: RAM driven from iaddr[owner] with ramREN=1.
    - iload[owner]=ramload; iwait[owner]=~ram_ready.
    - On ram_ready -> IDLE (single word).
- Completion cycle: the requester sees wait low in the same cycle ram_ready is high (combinational pass-through); no extra latency.
- Non-owners hold iwait=dwait=1 at all times.
- If dREN and dWEN are both high in DSERV, dWEN wins; this is illegal stimulus and the assertion flags it.
- The snooped peer is never granted while its ccwait=1; its own pending request is seen in the next IDLE.
- Minimum latency, coherent read, clean peer: IDLE->SNOOP->SNOOP_RESP->DSERV = 3 cycles before the first RAM access.

Decomposition:
- Shared package:
  - bus state enum (IDLE, SNOOP, SNOOP_RESP, PEER_WB, DSERV, ISERV), 3-bit encoding.
  - typedef for core index.
  - constants ADDR_W, WORD_W.
- One sub-module, rr_arbiter2: 2-way round-robin with priority class input. Outputs winner index and valid; holds rr_last.
- FSM plus muxing stays in the top.

Test Plan:
- Reset: nRST low mid-DSERV with ram_ready=0 -> next cycle ramREN=ramWEN=0, all waits 1, state IDLE.
- Core0 iREN, iaddr=0x40, RAM ready after 2 cycles with ramload=0xDEADBEEF -> iwait[0] low for 1 cycle, iload[0]=0xDEADBEEF, back to IDLE.
- Core0 dREN+cctrans, daddr=0x100, ccwrite=0, peer silent -> SNOOP cycle shows ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=0; then 2-word fill 0x100/0x104 served; IDLE when cctrans drops.
- Core1 write-miss (cctrans, ccwrite=1, daddr=0x200), core0 responds dWEN with 0xAAAA0000 to 0x200 -> ccinv[0]=1; RAM writes 0x200 before core1's read of 0x200; dwait[1] stays 1 throughout PEER_WB.
- Simultaneous core0 iREN and core1 dREN -> core1 granted first; core0 ISERV follows.
- Both cores dREN (cctrans=0) on consecutive idles: grants alternate 0,1,0,1; icache requests pending on both cores are served only when no dcache request is pending.
